reg_bank_sequencer: RTL

Multi-cycle controller that drives the register-bank encapsulation's control inputs (LATCH_REG, PC_MUX, RD_MUX, DATA_MUX, REG_GATE_A/B/C) for one ARMv4 instruction at a time. It accepts an instruction word over a valid/ready handshake, gates operands, starts the ALU and waits for it, writes the result back, and advances PC by 4 unless PC was the destination. It sits between the fetch unit and the register bank / ALU pair.

---
 rtl/arm_ctrl_pkg.sv | 45 ++++
 rtl/reg_bank_sequencer_if.sv | 11 +
 rtl/ir_class_decode.sv | 32 +++
 rtl/reg_bank_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared types and instruction-field constants for the register-bank sequencer.
package arm_ctrl_pkg;

    localparam int unsigned IR_W          = 32;
    localparam int unsigned COND_MSB      = 31;
    localparam int unsigned COND_LSB      = 28;
    localparam int unsigned OPCODE_MSB    = 24;
    localparam int unsigned OPCODE_LSB    = 21;
    localparam int unsigned I_BIT         = 25;
    localparam int unsigned L_BIT         = 24;
    localparam int unsigned RD_MSB        = 15;
    localparam int unsigned RD_LSB        = 12;
    localparam int unsigned SHIFT_REG_BIT = 4;
    localparam int unsigned PC_IDX        = 15;

    typedef enum logic [2:0] {
        IDLE, DECODE, OPERAND, EXEC, WB, PC_INC
    } state_t;

    typedef enum logic [1:0] {
        DP, BRANCH, OTHER
    } iclass_t;

    typedef struct packed {
        iclass_t iclass;
        logic    writes_rd;
        logic    uses_rm;
        logic    uses_rs;
        logic    rd_is_pc;
    } ir_info_t;

    typedef struct packed {
        logic ir_ready;
        logic alu_start;
        logic rd_mux;
        logic reg_gate_a;
        logic reg_gate_b;
        logic reg_gate_c;
        logic latch_reg;
        logic pc_mux;
        logic data_mux;
        logic instr_done;
    } ctrl_t;

endpackage

// File: rtl/reg_bank_sequencer_if.sv
// Instruction hand-off between fetch (master) and the sequencer (slave).
interface reg_bank_sequencer_if;
    import arm_ctrl_pkg::*;

    logic [IR_W-1:0] ir_in;
    logic            ir_valid;
    logic            ir_ready;

    modport master (output ir_in, output ir_valid, input  ir_ready);
    modport slave  (input  ir_in, input  ir_valid, output ir_ready);
endinterface

// File: rtl/ir_class_decode.sv
// Combinational classifier: instruction word -> class and operand/writeback usage.
module ir_class_decode
    import arm_ctrl_pkg::*;
(
    input  logic [IR_W-1:0] ir,
    output ir_info_t        info
);
    logic [3:0] w_opcode;
    logic       w_is_dp;
    logic       w_is_br;
    logic       w_is_cmp;
    logic       w_uses_rm;
    logic       w_unused_bits;

    assign w_opcode  = ir[OPCODE_MSB:OPCODE_LSB];
    assign w_is_dp   = (ir[27:26] == 2'b00);
    assign w_is_br   = (ir[27:25] == 3'b101);
    // TST/TEQ/CMP/CMN only set flags, so they never write Rd
    assign w_is_cmp  = w_is_dp && (w_opcode[3:2] == 2'b10);
    assign w_uses_rm = w_is_dp && !ir[I_BIT];

    always_comb begin
        info           = '0;
        info.iclass    = w_is_dp ? DP : (w_is_br ? BRANCH : OTHER);
        info.writes_rd = (w_is_dp && !w_is_cmp) || w_is_br;
        info.uses_rm   = w_uses_rm;
        info.uses_rs   = w_uses_rm && ir[SHIFT_REG_BIT];
        info.rd_is_pc  = (ir[RD_MSB:RD_LSB] == 4'(PC_IDX));
    end

    assign w_unused_bits = ^{ir[COND_MSB:COND_LSB], ir[20:16], ir[11:5], ir[3:0]};
endmodule

// File: rtl/reg_bank_sequencer.sv
// Multi-cycle sequencer driving register-bank write controls and operand gates
// for one instruction at a time, with ALU timeout and retired-instruction count.
module reg_bank_sequencer
    import arm_ctrl_pkg::*;
#(
    parameter int unsigned ALU_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    reg_bank_sequencer_if.slave fetch,
    input  logic                cond_pass,
    output logic                alu_start,
    input  logic                alu_done,
    output logic [IR_W-1:0]     ir_o,
    output logic                latch_reg,
    output logic                pc_mux,
    output logic                rd_mux,
    output logic                data_mux,
    output logic                reg_gate_a,
    output logic                reg_gate_b,
    output logic                reg_gate_c,
    output logic                instr_done,
    output logic                err,
    output logic [CNT_W-1:0]    retired
);
    localparam int unsigned TMO_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IR_W-1:0]  r_ir;
    logic [IR_W-1:0]  w_ir_nxt;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] w_tmo_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_abort;
    logic             w_wb_pc;
    logic [CNT_W-1:0] r_retired;
    ctrl_t            r_ctrl;
    ctrl_t            w_ctrl_nxt;
    ir_info_t         w_info;

    ir_class_decode u_decode (
        .ir   (r_ir),
        .info (w_info)
    );

    assign w_wb_pc = (w_info.iclass == BRANCH) || w_info.rd_is_pc;

    // Next state, then the control word that the next state presents
    always_comb begin
        w_state_nxt = r_state;
        w_ir_nxt    = r_ir;
        w_tmo_nxt   = r_tmo;
        w_err_nxt   = r_err;
        w_abort     = 1'b0;

        case (r_state)
            IDLE: begin
                if (fetch.ir_valid && r_ctrl.ir_ready) begin
                    w_ir_nxt    = fetch.ir_in;
                    w_state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (!cond_pass) begin
                    w_state_nxt = PC_INC;
                end else if (w_info.iclass == DP) begin
                    w_state_nxt = OPERAND;
                end else if (w_info.iclass == BRANCH) begin
                    w_state_nxt = OPERAND;
                    if (r_ir[L_BIT]) w_err_nxt = 1'b1;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = PC_INC;
                end
            end
            OPERAND: begin
                w_state_nxt = EXEC;
                w_tmo_nxt   = '0;
            end
            EXEC: begin
                // alu_done has priority over the timeout on the same cycle
                if (alu_done) begin
                    w_state_nxt = w_info.writes_rd ? WB : PC_INC;
                end else if (r_tmo == TMO_W'(ALU_TIMEOUT - 1)) begin
                    w_abort     = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            WB:      w_state_nxt = w_wb_pc ? IDLE : PC_INC;
            PC_INC:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase

        w_ctrl_nxt = '0;
        case (w_state_nxt)
            IDLE: begin
                // An abort spends its first IDLE cycle as the done cycle
                w_ctrl_nxt.ir_ready   = !w_abort;
                w_ctrl_nxt.instr_done = w_abort;
            end
            OPERAND: begin
                w_ctrl_nxt.alu_start  = 1'b1;
                w_ctrl_nxt.rd_mux     = 1'b1;
                w_ctrl_nxt.reg_gate_a = 1'b1;
                w_ctrl_nxt.reg_gate_b = w_info.uses_rm;
                w_ctrl_nxt.reg_gate_c = w_info.uses_rs;
            end
            EXEC: begin
                w_ctrl_nxt.rd_mux     = 1'b1;
                w_ctrl_nxt.reg_gate_a = 1'b1;
                w_ctrl_nxt.reg_gate_b = w_info.uses_rm;
                w_ctrl_nxt.reg_gate_c = w_info.uses_rs;
            end
            WB: begin
                w_ctrl_nxt.latch_reg  = 1'b1;
                w_ctrl_nxt.data_mux   = 1'b1;
                w_ctrl_nxt.rd_mux     = 1'b1;
                w_ctrl_nxt.pc_mux     = w_wb_pc;
                w_ctrl_nxt.instr_done = w_wb_pc;
            end
            PC_INC: begin
                w_ctrl_nxt.latch_reg  = 1'b1;
                w_ctrl_nxt.pc_mux     = 1'b1;
                w_ctrl_nxt.instr_done = 1'b1;
            end
            default: w_ctrl_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_ir            <= '0;
            r_tmo           <= '0;
            r_err           <= 1'b0;
            r_retired       <= '0;
            r_ctrl          <= '0;
            r_ctrl.ir_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ir    <= w_ir_nxt;
            r_tmo   <= w_tmo_nxt;
            r_err   <= w_err_nxt;
            r_ctrl  <= w_ctrl_nxt;
            if (w_ctrl_nxt.instr_done && !w_abort) r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign fetch.ir_ready = r_ctrl.ir_ready;
    assign alu_start      = r_ctrl.alu_start;
    assign rd_mux         = r_ctrl.rd_mux;
    assign reg_gate_a     = r_ctrl.reg_gate_a;
    assign reg_gate_b     = r_ctrl.reg_gate_b;
    assign reg_gate_c     = r_ctrl.reg_gate_c;
    assign latch_reg      = r_ctrl.latch_reg;
    assign pc_mux         = r_ctrl.pc_mux;
    assign data_mux       = r_ctrl.data_mux;
    assign instr_done     = r_ctrl.instr_done;
    assign ir_o           = r_ir;
    assign err            = r_err;
    assign retired        = r_retired;
endmodule
